// File: rtl/video_capture_pkg.sv
// video_capture_pkg
// Default video timing shared by the SoC video generator and the capture
// block, so both ends agree on pixel rate, sync widths and frame geometry.
// Also holds the capture state encoding and the byte-address helper.
package video_capture_pkg;

  localparam int VID_CLK_PER_PIXEL = 4;
  localparam int VID_HSYNC_MIN     = 8;
  localparam int VID_VSYNC_MIN     = 64;
  localparam int VID_H_OFFSET      = 32;
  localparam int VID_H_PIXELS      = 64;
  localparam int VID_V_OFFSET      = 2;
  localparam int VID_V_LINES       = 32;
  localparam int VID_ADDR_W        = 8;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_PORCH  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_WAIT   = 2'd3
  } cap_state_t;

  // Capture RAM is row-major, one byte per 8 pixels.
  function automatic int byte_addr(input int row, input int col, input int stride);
    return row * stride + col;
  endfunction

endpackage

// File: rtl/video_capture_sync_classifier.sv
// sync_classifier
// Detects videoSync edges and measures the high time of each sync pulse
// with a saturating counter; on the falling edge the pulse is classified.
// Ports:
//   clk, resetN         clock, async active-low reset
//   videoSync           sync input, active high, synchronous to clk
//   hsyncPulse          fall of a pulse with HSYNC_MIN <= width < VSYNC_MIN
//   vsyncPulse          fall of a pulse with width >= VSYNC_MIN
//   runtPulse           fall of a pulse shorter than HSYNC_MIN
//   syncRise            rising edge of videoSync
// All pulse outputs are combinational, valid in the edge cycle.
module sync_classifier
  import video_capture_pkg::*;
#(
  parameter int HSYNC_MIN = VID_HSYNC_MIN,
  parameter int VSYNC_MIN = VID_VSYNC_MIN
) (
  input  logic clk,
  input  logic resetN,
  input  logic videoSync,
  output logic hsyncPulse,
  output logic vsyncPulse,
  output logic runtPulse,
  output logic syncRise
);

  localparam int CW = $clog2(VSYNC_MIN + 1);

  logic          sync_d;
  logic [CW-1:0] sync_cnt;
  logic          sync_fall;

  assign syncRise  = videoSync & ~sync_d;
  assign sync_fall = ~videoSync & sync_d;

  // The rising-edge clock itself is the first high clock, so restart at 1.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync_d   <= 1'b0;
      sync_cnt <= '0;
    end else begin
      sync_d <= videoSync;
      if (syncRise)
        sync_cnt <= CW'(1);
      else if (videoSync && (sync_cnt < CW'(VSYNC_MIN)))
        sync_cnt <= sync_cnt + 1'b1;
    end
  end

  assign vsyncPulse = sync_fall && (sync_cnt >= CW'(VSYNC_MIN));
  assign hsyncPulse = sync_fall && (sync_cnt <  CW'(VSYNC_MIN)) && (sync_cnt >= CW'(HSYNC_MIN));
  assign runtPulse  = sync_fall && (sync_cnt <  CW'(HSYNC_MIN));

endmodule

// File: rtl/video_capture.sv
// video_capture
// Decodes the videoSync/videoPixel stream into frame coordinates and packs
// visible pixels MSB-first into bytes for a capture RAM.
// Ports:
//   clk, resetN         clock, async active-low reset
//   videoSync           sync, active high (width selects hsync/vsync)
//   videoPixel          pixel data
//   wrEn/wrAddr/wrData  one-cycle RAM write, addr = row*(H_PIXELS/8)+col
//   locked              set by the first vsync, held until reset
//   frameDone           pulses with the write of the last byte of a frame
//   syncErr             pulses after a runt sync or a sync during ACTIVE
//
// state  | meaning
// HUNT   | not locked, waiting for a vsync
// PORCH  | counting H_OFFSET clocks from the sync falling edge
// ACTIVE | sampling H_PIXELS pixels at mid-pixel
// WAIT   | idle until the next sync falling edge
module video_capture
  import video_capture_pkg::*;
#(
  parameter int CLK_PER_PIXEL = VID_CLK_PER_PIXEL,
  parameter int HSYNC_MIN     = VID_HSYNC_MIN,
  parameter int VSYNC_MIN     = VID_VSYNC_MIN,
  parameter int H_OFFSET      = VID_H_OFFSET,
  parameter int H_PIXELS      = VID_H_PIXELS,
  parameter int V_OFFSET      = VID_V_OFFSET,
  parameter int V_LINES       = VID_V_LINES,
  parameter int ADDR_W        = VID_ADDR_W
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              videoSync,
  input  logic              videoPixel,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [7:0]        wrData,
  output logic              locked,
  output logic              frameDone,
  output logic              syncErr
);

  localparam int STRIDE = H_PIXELS / 8;
  localparam int LW     = $clog2(V_OFFSET + V_LINES) + 1;
  localparam int DW     = $clog2(H_OFFSET + 1);
  localparam int PW     = (CLK_PER_PIXEL > 1) ? $clog2(CLK_PER_PIXEL) : 1;
  localparam int SW     = $clog2(H_PIXELS) + 1;
  localparam int CW     = $clog2(STRIDE) + 1;

  cap_state_t    state, state_next;
  logic          hsync_pulse, vsync_pulse, runt_pulse, sync_rise;
  logic          line_start;
  logic [LW-1:0] line_idx;
  logic [LW-1:0] row;
  logic          visible;
  logic [DW-1:0] dot_cnt;
  logic [PW-1:0] phase;
  logic [SW-1:0] pix_cnt;
  logic [CW-1:0] col_cnt;
  logic [6:0]    shift_q;
  logic          sample;
  logic [31:0]   addr_full;

  sync_classifier #(
    .HSYNC_MIN (HSYNC_MIN),
    .VSYNC_MIN (VSYNC_MIN)
  ) u_sync (
    .clk        (clk),
    .resetN     (resetN),
    .videoSync  (videoSync),
    .hsyncPulse (hsync_pulse),
    .vsyncPulse (vsync_pulse),
    .runtPulse  (runt_pulse),
    .syncRise   (sync_rise)
  );

  // An hsync before lock carries no line reference and is ignored.
  assign line_start = vsync_pulse | (hsync_pulse & locked);
  assign row        = line_idx - LW'(V_OFFSET);
  assign visible    = (line_idx >= LW'(V_OFFSET)) && (line_idx < LW'(V_OFFSET + V_LINES));
  // A rising sync edge aborts the line, so it also suppresses a coincident sample.
  assign sample     = (state == ST_ACTIVE) && (phase == PW'(CLK_PER_PIXEL / 2)) && !sync_rise;
  assign addr_full  = 32'(byte_addr(int'(row), int'(col_cnt), STRIDE));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      state <= ST_HUNT;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (line_start)
      state_next = ST_PORCH;
    else if (sync_rise && (state != ST_HUNT))
      state_next = ST_WAIT;
    else begin
      case (state)
        ST_PORCH:  if (dot_cnt == DW'(H_OFFSET - 1))
                     state_next = visible ? ST_ACTIVE : ST_WAIT;
        ST_ACTIVE: if (sample && (pix_cnt == SW'(H_PIXELS - 1)))
                     state_next = ST_WAIT;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      line_idx  <= '0;
      dot_cnt   <= '0;
      phase     <= '0;
      pix_cnt   <= '0;
      col_cnt   <= '0;
      shift_q   <= '0;
      wrEn      <= 1'b0;
      wrAddr    <= '0;
      wrData    <= '0;
      locked    <= 1'b0;
      frameDone <= 1'b0;
      syncErr   <= 1'b0;
    end else begin
      wrEn      <= 1'b0;
      frameDone <= 1'b0;
      syncErr   <= runt_pulse | (sync_rise & (state == ST_ACTIVE));

      if (vsync_pulse) begin
        locked   <= 1'b1;
        line_idx <= '0;
      end else if (hsync_pulse && locked && (line_idx != {LW{1'b1}})) begin
        line_idx <= line_idx + 1'b1;
      end

      if (line_start) begin
        // The edge cycle is clock 0, so the next clock is dot 1.
        dot_cnt <= DW'(1);
        phase   <= '0;
        pix_cnt <= '0;
        col_cnt <= '0;
        shift_q <= '0;
      end else begin
        if (state == ST_PORCH)
          dot_cnt <= dot_cnt + 1'b1;
        if (state == ST_ACTIVE)
          phase <= phase + 1'b1;
        if (sample) begin
          shift_q <= {shift_q[5:0], videoPixel};
          pix_cnt <= pix_cnt + 1'b1;
          if (pix_cnt[2:0] == 3'd7) begin
            wrEn      <= 1'b1;
            wrData    <= {shift_q, videoPixel};
            wrAddr    <= ADDR_W'(addr_full);
            col_cnt   <= col_cnt + 1'b1;
            frameDone <= (row == LW'(V_LINES - 1)) && (col_cnt == CW'(STRIDE - 1));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_video_capture.sv
module tb_video_capture;

  localparam int H_OFFSET = 32;
  localparam int CPP      = 4;
  localparam int STRIDE   = 8;
  localparam int V_LINES  = 32;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       fd;
    int         cyc;
  } wr_t;

  logic       clk;
  logic       resetN;
  logic       videoSync;
  logic       videoPixel;
  logic       wrEn;
  logic [7:0] wrAddr;
  logic [7:0] wrData;
  logic       locked;
  logic       frameDone;
  logic       syncErr;

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  fall_cyc = 0;
  int  fd_cnt = 0;
  wr_t wr_q[$];
  int  err_q[$];

  video_capture dut (
    .clk        (clk),
    .resetN     (resetN),
    .videoSync  (videoSync),
    .videoPixel (videoPixel),
    .wrEn       (wrEn),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .locked     (locked),
    .frameDone  (frameDone),
    .syncErr    (syncErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ends on the negedge just before clock 0 of the new line.
  task automatic do_sync(input int len);
    videoSync = 1'b1;
    tick(len);
    videoSync = 1'b0;
    fall_cyc = cyc + 1;
  endtask

  task automatic runt();
    videoSync = 1'b1;
    tick(4);
    videoSync = 1'b0;
    err_q.push_back(cyc + 1);
  endtask

  // Drives npix pixels of bits (MSB = pixel 0) and queues a write for each full byte.
  task automatic vis_line(input int row, input logic [63:0] bits, input int npix);
    wr_t e;
    tick(H_OFFSET);
    for (int k = 0; k < npix; k++) begin
      videoPixel = bits[63-k];
      if ((k % 8) == 7) begin
        e.addr = 8'(row * STRIDE + k / 8);
        e.data = bits[63-(k-7) -: 8];
        e.fd   = (row == V_LINES - 1) && (k / 8 == STRIDE - 1);
        e.cyc  = fall_cyc + H_OFFSET + CPP / 2 + CPP * k;
        wr_q.push_back(e);
      end
      tick(CPP);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    int  ec;
    if (wrEn) begin
      if (wr_q.size() == 0)
        check("wr_unexpected", wrEn, 1'b0);
      else begin
        e = wr_q.pop_front();
        check("wr_addr", wrAddr, e.addr);
        check("wr_data", wrData, e.data);
        check("wr_frameDone", frameDone, e.fd);
        check("wr_cycle", cyc, e.cyc);
      end
    end else if (frameDone) begin
      check("frameDone_without_wr", frameDone, 1'b0);
    end
    if (frameDone) fd_cnt++;
    if (syncErr) begin
      if (err_q.size() == 0)
        check("syncErr_unexpected", syncErr, 1'b0);
      else begin
        ec = err_q.pop_front();
        check("syncErr_cycle", cyc, ec);
      end
    end
  end

  initial begin
    logic [7:0] rb;
    resetN     = 1'b0;
    videoSync  = 1'b0;
    videoPixel = 1'b0;
    tick(3);
    check("rst_wrEn", wrEn, 1'b0);
    check("rst_wrAddr", wrAddr, 8'h00);
    check("rst_wrData", wrData, 8'h00);
    check("rst_locked", locked, 1'b0);
    check("rst_frameDone", frameDone, 1'b0);
    check("rst_syncErr", syncErr, 1'b0);
    resetN = 1'b1;
    tick(2);

    // First vsync: locked rises the cycle after the fall, no writes.
    videoSync = 1'b1;
    tick(70);
    check("locked_before_fall", locked, 1'b0);
    videoSync = 1'b0;
    fall_cyc = cyc + 1;
    tick(1);
    check("locked_after_fall", locked, 1'b1);
    tick(300);
    do_sync(10); tick(300);
    do_sync(10); vis_line(0, {8{8'hAA}}, 64); tick(4);

    // Runt sync in the porch of a blank line.
    do_sync(70); tick(10); runt(); tick(300);
    do_sync(10); tick(300);
    do_sync(10); vis_line(0, {8{8'h0F}}, 64); tick(4);

    // Sync rising after 20 pixels: two bytes, partial byte dropped.
    do_sync(10); vis_line(1, {8'h11, 8'h22, 8'h3C, 40'h0}, 20);
    videoSync = 1'b1;
    err_q.push_back(cyc + 1);
    tick(10);
    videoSync = 1'b0;
    fall_cyc = cyc + 1;
    vis_line(2, 64'h0123_4567_89AB_CDEF, 64); tick(4);

    // Full frame, line r filled with r.
    fd_cnt = 0;
    do_sync(70); tick(300);
    do_sync(10); tick(300);
    for (int r = 0; r < V_LINES; r++) begin
      rb = 8'(r);
      do_sync(10);
      vis_line(r, {8{rb}}, 64);
      tick(4);
    end
    do_sync(10); tick(300);
    check("frame_done_count", fd_cnt, 1);

    // Async reset mid-line, then hsync only, then vsync restarts at addr 0.
    do_sync(70); tick(300);
    do_sync(10); tick(300);
    do_sync(10);
    videoPixel = 1'b1;
    tick(40);
    resetN = 1'b0;
    #1;
    check("async_rst_locked", locked, 1'b0);
    check("async_rst_wrAddr", wrAddr, 8'h00);
    check("async_rst_wrData", wrData, 8'h00);
    check("async_rst_wrEn", wrEn, 1'b0);
    tick(2);
    resetN = 1'b1;
    tick(2);
    do_sync(10); tick(300);
    do_sync(10); tick(300);
    check("locked_after_hsync_only", locked, 1'b0);
    videoPixel = 1'b0;
    do_sync(70); tick(300);
    do_sync(10); tick(300);
    do_sync(10); vis_line(0, {8{8'h5A}}, 64);
    tick(20);

    check("wr_queue_drained", wr_q.size(), 0);
    check("syncErr_queue_drained", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
